// File: rtl/uart_tx_arbiter.sv
// Round-robin line arbiter: one tile owns the shared UART TX per text line; grant one cycle after request, data combinational.
// Backpressure passes straight through (stall is never idle); define UART_ARB_TAG_EN to prefix each grant with "<hex id>:".
module uart_tx_arbiter #(
   parameter int         NUM_REQ      = 9,
   parameter logic [7:0] EOL_CHAR     = 8'h0A,
   parameter int         MAX_LINE     = 256,
   parameter int         IDLE_TIMEOUT = 1024
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [NUM_REQ-1:0]   in_valid_i,
   input  logic [NUM_REQ*8-1:0] in_data_i,
   output logic [NUM_REQ-1:0]   in_ready_o,
   output logic                 tx_valid_o,
   output logic [7:0]           tx_data_o,
   input  logic                 tx_ready_i,
   output logic [NUM_REQ-1:0]   grant_o,
   output logic                 busy_o
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_LINE + 1);
   localparam int IW = $clog2(IDLE_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
`ifdef UART_ARB_TAG_EN
      TAG_ID  = 2'd1,
      TAG_SEP = 2'd2,
`endif
      PASS    = 2'd3
   } state_t;

   state_t             state, state_nx;
   logic [GW-1:0]      g_idx, rr_ptr, sel_idx;
   logic               sel_found;
   logic [GW:0]        scan_sum;
   logic [NUM_REQ-1:0] grant_q;
   logic [BW-1:0]      byte_cnt;
   logic [IW-1:0]      idle_cnt;
   logic               g_vld, hs, rel_line, last_byte, timed_out;
   logic [7:0]         g_dat;

   assign g_vld     = in_valid_i[g_idx];
   assign g_dat     = in_data_i[{g_idx, 3'b000} +: 8];
   assign last_byte = (g_dat == EOL_CHAR) || (byte_cnt == BW'(MAX_LINE - 1));
   assign timed_out = !g_vld && (idle_cnt == IW'(IDLE_TIMEOUT - 1));
   assign grant_o   = grant_q;
   assign busy_o    = (state != IDLE);

`ifdef UART_ARB_TAG_EN
   logic [7:0] g_ext, hex_chr;
   assign g_ext   = 8'(g_idx);
   assign hex_chr = (g_ext < 8'd10) ? (8'd48 + g_ext) : (8'd55 + g_ext);
`endif

   // Round-robin scan starting at rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_sum  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_sum = {1'b0, rr_ptr} + (GW+1)'(k);
         if (scan_sum >= (GW+1)'(NUM_REQ))
            scan_sum = scan_sum - (GW+1)'(NUM_REQ);
         if (!sel_found && in_valid_i[scan_sum[GW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = scan_sum[GW-1:0];
         end
      end
   end

   always_comb begin
      state_nx   = state;
      tx_valid_o = 1'b0;
      tx_data_o  = 8'h00;
      in_ready_o = '0;
      hs         = 1'b0;
      rel_line   = 1'b0;
      case (state)
         IDLE: begin
`ifdef UART_ARB_TAG_EN
            if (sel_found) state_nx = TAG_ID;
`else
            if (sel_found) state_nx = PASS;
`endif
         end
`ifdef UART_ARB_TAG_EN
         TAG_ID: begin
            tx_valid_o = 1'b1;
            tx_data_o  = hex_chr;
            if (tx_ready_i) state_nx = TAG_SEP;
         end
         TAG_SEP: begin
            tx_valid_o = 1'b1;
            tx_data_o  = 8'h3A;
            if (tx_ready_i) state_nx = PASS;
         end
`endif
         PASS: begin
            tx_valid_o        = g_vld;
            tx_data_o         = g_dat;
            in_ready_o[g_idx] = tx_ready_i;
            hs                = g_vld && tx_ready_i;
            rel_line          = (hs && last_byte) || timed_out;
            if (rel_line) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state    <= IDLE;
         g_idx    <= '0;
         grant_q  <= '0;
         rr_ptr   <= '0;
         byte_cnt <= '0;
         idle_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && sel_found) begin
            g_idx    <= sel_idx;
            grant_q  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
            byte_cnt <= '0;
            idle_cnt <= '0;
         end else if (state == PASS) begin
            if (rel_line) begin
               grant_q <= '0;
               rr_ptr  <= (g_idx == GW'(NUM_REQ - 1)) ? '0 : g_idx + GW'(1);
            end
            // A stalled but valid requester leaves idle_cnt untouched.
            if (hs) begin
               byte_cnt <= byte_cnt + BW'(1);
               idle_cnt <= '0;
            end else if (!g_vld) begin
               idle_cnt <= idle_cnt + IW'(1);
            end
         end
      end
   end

endmodule
